// File: rtl/rv_mon_pkg.sv
// Shared types for the ready/valid handshake monitor: channel FSM states,
// error codes, the per-channel error pulse bundle and the code priority helper.
package rv_mon_pkg;

    typedef enum logic {IDLE, WAIT} rv_ch_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_VALID_DROP,
        ERR_DATA_CHG,
        ERR_TIMEOUT
    } rv_err_code_e;

    // One-cycle violation pulses raised by a channel monitor.
    typedef struct packed {
        logic drop;
        logic chg;
        logic tmo;
    } rv_ch_err_t;

    // Collapse a channel's simultaneous pulses to a single code:
    // VALID_DROP beats DATA_CHG beats TIMEOUT.
    function automatic rv_err_code_e err_prio(input rv_ch_err_t e);
        rv_err_code_e code;
        code = ERR_NONE;
        if (e.drop)
            code = ERR_VALID_DROP;
        else if (e.chg)
            code = ERR_DATA_CHG;
        else if (e.tmo)
            code = ERR_TIMEOUT;
        return code;
    endfunction

endpackage

// File: rtl/rv_chan_monitor.sv
// Single-channel ready/valid checker: IDLE/WAIT FSM, payload capture at stall
// start, saturating stall counter, saturating transfer counter with clear,
// and combinational violation pulses for the cycle being observed.
module rv_chan_monitor
    import rv_mon_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 64
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              clr,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  xfer_cnt,
    output rv_ch_err_t        err
);

    // Stall counter only needs to reach MAX_STALL; it parks there so the
    // timeout crossing is seen once per stall episode.
    localparam int               SC_W      = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    rv_ch_state_e      state, state_nxt;
    logic [DATA_W-1:0] cap;
    logic [SC_W-1:0]   stall_cnt, stall_nxt;
    logic              capture;
    logic              xfer;

    // Next state, stall count and violation pulses from the current cycle.
    always_comb begin
        state_nxt = state;
        stall_nxt = stall_cnt;
        capture   = 1'b0;
        xfer      = 1'b0;
        err       = '0;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (ready) begin
                        xfer = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = WAIT;
                        stall_nxt = SC_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!valid) begin
                    err.drop  = 1'b1;
                    state_nxt = IDLE;
                    stall_nxt = '0;
                end else begin
                    // Payload is held against the value seen when the stall began.
                    err.chg = (data !== cap);
                    if (ready) begin
                        xfer      = 1'b1;
                        state_nxt = IDLE;
                        stall_nxt = '0;
                    end else if (stall_cnt != STALL_MAX) begin
                        stall_nxt = stall_cnt + SC_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (MAX_STALL != 0)
            err.tmo = valid && !ready && (stall_nxt == STALL_MAX) && (stall_cnt != STALL_MAX);
    end

    // FSM, stall counter and captured payload; reset drops any stall in progress.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= IDLE;
            stall_cnt <= '0;
            cap       <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_nxt;
            if (capture)
                cap <= data;
        end
    end

    // Saturating transfer counter; a transfer in the clear cycle survives the clear.
    always_ff @(posedge CLK) begin
        if (!RESETN)
            xfer_cnt <= '0;
        else if (clr)
            xfer_cnt <= xfer ? CNT_W'(1) : '0;
        else if (xfer && (xfer_cnt != CNT_MAX))
            xfer_cnt <= xfer_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rv_handshake_monitor.sv
// Multi-channel ready/valid protocol monitor, intended for use via
//   bind <dut> rv_handshake_monitor #(...) mon_inst (.*);
// Adds sticky error status, first-error arbitration and the clear path on top
// of NUM_CH rv_chan_monitor instances.
// Optional: define RV_MON_ASSERT_EN to elaborate per-channel concurrent SVA.
module rv_handshake_monitor
    import rv_mon_pkg::*;
#(
    parameter  int NUM_CH    = 3,
    parameter  int DATA_W    = 4,
    parameter  int CNT_W     = 16,
    parameter  int MAX_STALL = 64,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH*CNT_W-1:0]  xfer_cnt,
    output logic [NUM_CH-1:0]        err_valid_drop,
    output logic [NUM_CH-1:0]        err_data_chg,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic                     err_any,
    output logic [CH_W-1:0]          first_err_chan,
    output logic [1:0]               first_err_code
);

    rv_ch_err_t [NUM_CH-1:0] ch_err;
    logic [NUM_CH-1:0]       drop_vec, chg_vec, tmo_vec;
    logic                    new_hit;
    logic [CH_W-1:0]         new_chan;
    rv_err_code_e            new_code;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rv_chan_monitor #(
            .DATA_W   (DATA_W),
            .CNT_W    (CNT_W),
            .MAX_STALL(MAX_STALL)
        ) u_ch (
            .CLK     (CLK),
            .RESETN  (RESETN),
            .clr     (clr),
            .valid   (valid[i]),
            .ready   (ready[i]),
            .data    (data[i*DATA_W +: DATA_W]),
            .xfer_cnt(xfer_cnt[i*CNT_W +: CNT_W]),
            .err     (ch_err[i])
        );

`ifdef RV_MON_ASSERT_EN
        a_valid_hold: assert property (@(posedge CLK) disable iff (!RESETN)
            (valid[i] && !ready[i]) |=> valid[i])
            else $error("rv_handshake_monitor ch%0d: valid dropped while stalled", i);

        a_data_stable: assert property (@(posedge CLK) disable iff (!RESETN)
            (valid[i] && !ready[i]) |=> (!valid[i] ||
                (data[i*DATA_W +: DATA_W] === $past(data[i*DATA_W +: DATA_W]))))
            else $error("rv_handshake_monitor ch%0d: payload changed while stalled", i);

        a_no_x: assert property (@(posedge CLK) disable iff (!RESETN)
            !$isunknown({valid[i], ready[i]}))
            else $error("rv_handshake_monitor ch%0d: X/Z on valid or ready", i);

        if (MAX_STALL != 0) begin : g_stall_sva
            a_stall_bound: assert property (@(posedge CLK) disable iff (!RESETN)
                !ch_err[i].tmo)
                else $error("rv_handshake_monitor ch%0d: stall reached %0d cycles", i, MAX_STALL);
        end
`else
        // Status outputs alone report protocol violations in this build.
`endif
    end

    // Regroup per-channel pulses by error kind and pick the first-error candidate:
    // scanning down means the lowest channel index is the one left standing.
    always_comb begin
        drop_vec = '0;
        chg_vec  = '0;
        tmo_vec  = '0;
        new_hit  = 1'b0;
        new_chan = '0;
        new_code = ERR_NONE;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_vec[i] = ch_err[i].drop;
            chg_vec[i]  = ch_err[i].chg;
            tmo_vec[i]  = ch_err[i].tmo;
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (|ch_err[i]) begin
                new_hit  = 1'b1;
                new_chan = CH_W'(i);
                new_code = err_prio(ch_err[i]);
            end
        end
    end

    // Sticky error bits; on clear, this cycle's pulses still land.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            err_valid_drop <= '0;
            err_data_chg   <= '0;
            err_timeout    <= '0;
        end else if (clr) begin
            err_valid_drop <= drop_vec;
            err_data_chg   <= chg_vec;
            err_timeout    <= tmo_vec;
        end else begin
            err_valid_drop <= err_valid_drop | drop_vec;
            err_data_chg   <= err_data_chg | chg_vec;
            err_timeout    <= err_timeout | tmo_vec;
        end
    end

    // First-error record: open while empty, or reopened by clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            first_err_chan <= '0;
            first_err_code <= ERR_NONE;
        end else if (clr || (first_err_code == ERR_NONE)) begin
            first_err_chan <= new_hit ? new_chan : '0;
            first_err_code <= new_code;
        end
    end

    assign err_any = |{err_valid_drop, err_data_chg, err_timeout};

endmodule

// File: tb/tb_rv_handshake_monitor.sv
// Self-checking bench for rv_handshake_monitor: directed scenarios against
// fixed expectations plus a randomized run against a run-length reference model.
module tb_rv_handshake_monitor;

    localparam int NCH  = 3;
    localparam int DW   = 4;
    localparam int MAXS = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            clr = 1'b0;
    logic [NCH-1:0]  valid = '0;
    logic [NCH-1:0]  ready = '0;
    logic [NCH*DW-1:0] data = '0;

    logic [NCH*16-1:0] xfer_cnt;
    logic [NCH-1:0]    err_valid_drop, err_data_chg, err_timeout;
    logic              err_any;
    logic [1:0]        first_err_chan, first_err_code;

    logic [NCH*3-1:0]  s_xfer_cnt;
    logic [NCH-1:0]    s_err_valid_drop, s_err_data_chg, s_err_timeout;
    logic              s_err_any;
    logic [1:0]        s_first_err_chan, s_first_err_code;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: length of the current run of stalled cycles,
    // payload seen at the start of that run, and the expected status.
    int         run   [NCH];
    logic [3:0] start_d [NCH];
    int         cnt   [NCH];
    logic [NCH-1:0] m_drop, m_chg, m_tmo;
    int         m_fchan, m_fcode;

    always #5 clk = ~clk;

    rv_handshake_monitor #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(16), .MAX_STALL(MAXS)) dut (
        .CLK(clk), .RESETN(rstn), .clr(clr), .valid(valid), .ready(ready), .data(data),
        .xfer_cnt(xfer_cnt), .err_valid_drop(err_valid_drop), .err_data_chg(err_data_chg),
        .err_timeout(err_timeout), .err_any(err_any),
        .first_err_chan(first_err_chan), .first_err_code(first_err_code)
    );

    rv_handshake_monitor #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(3), .MAX_STALL(MAXS)) dut_s (
        .CLK(clk), .RESETN(rstn), .clr(clr), .valid(valid), .ready(ready), .data(data),
        .xfer_cnt(s_xfer_cnt), .err_valid_drop(s_err_valid_drop), .err_data_chg(s_err_data_chg),
        .err_timeout(s_err_timeout), .err_any(s_err_any),
        .first_err_chan(s_first_err_chan), .first_err_code(s_first_err_code)
    );

    // Advance one clock edge, updating the model from the inputs applied this cycle.
    task automatic tick();
        logic [NCH-1:0] drop, chg, tmo;
        if (!rstn) begin
            for (int c = 0; c < NCH; c++) begin
                run[c] = 0; start_d[c] = '0; cnt[c] = 0;
            end
            m_drop = '0; m_chg = '0; m_tmo = '0; m_fchan = 0; m_fcode = 0;
        end else begin
            drop = '0; chg = '0; tmo = '0;
            if (clr) begin
                for (int c = 0; c < NCH; c++) cnt[c] = 0;
                m_drop = '0; m_chg = '0; m_tmo = '0; m_fchan = 0; m_fcode = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                logic [3:0] d;
                d = data[c*DW +: DW];
                if (run[c] > 0 && !valid[c]) drop[c] = 1'b1;
                if (run[c] > 0 && valid[c] && (d !== start_d[c])) chg[c] = 1'b1;
                if (valid[c] && !ready[c]) begin
                    if (run[c] == 0) start_d[c] = d;
                    run[c] = run[c] + 1;
                    if (run[c] == MAXS) tmo[c] = 1'b1;
                end else begin
                    run[c] = 0;
                end
                if (valid[c] && ready[c]) cnt[c] = cnt[c] + 1;
            end
            m_drop = m_drop | drop;
            m_chg  = m_chg | chg;
            m_tmo  = m_tmo | tmo;
            if (m_fcode == 0) begin
                for (int c = NCH - 1; c >= 0; c--) begin
                    if (drop[c])     begin m_fchan = c; m_fcode = 1; end
                    else if (chg[c]) begin m_fchan = c; m_fcode = 2; end
                    else if (tmo[c]) begin m_fchan = c; m_fcode = 3; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; clr = 1'b0; valid = '0; ready = '0; data = '0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (xfer_cnt !== '0) begin n_bad++; $display("FAIL reset_xfer_cnt got %h want 0", xfer_cnt); end
        n_cmp++; if ({err_valid_drop, err_data_chg, err_timeout} !== '0) begin n_bad++;
            $display("FAIL reset_err_bits got %b want 0", {err_valid_drop, err_data_chg, err_timeout}); end
        n_cmp++; if (err_any !== 1'b0) begin n_bad++; $display("FAIL reset_err_any got %b want 0", err_any); end
        n_cmp++; if ({first_err_chan, first_err_code} !== 4'h0) begin n_bad++;
            $display("FAIL reset_first_err got %h want 0", {first_err_chan, first_err_code}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 3'b010; ready = 3'b010; data = 12'h0a0;
        for (int k = 0; k < 10; k++) begin
            tick();
            data[4 +: 4] = 4'(k);
        end
        valid = '0; ready = '0;
        tick();
        n_cmp++; if (xfer_cnt[16 +: 16] !== 16'd10) begin n_bad++; $display("FAIL b2b_ch1_cnt got %0d want 10", xfer_cnt[16 +: 16]); end
        n_cmp++; if (xfer_cnt[0 +: 16] !== 16'd0 || xfer_cnt[32 +: 16] !== 16'd0) begin n_bad++;
            $display("FAIL b2b_other_cnt got %0d/%0d want 0/0", xfer_cnt[0 +: 16], xfer_cnt[32 +: 16]); end
        n_cmp++; if (err_any !== 1'b0) begin n_bad++; $display("FAIL b2b_err_any got %b want 0", err_any); end
        n_cmp++; if (s_xfer_cnt[3 +: 3] !== 3'd7) begin n_bad++; $display("FAIL b2b_sat_ch1 got %0d want 7", s_xfer_cnt[3 +: 3]); end
    endtask

    task automatic test_valid_drop();
        do_reset();
        valid = 3'b001; ready = 3'b000; data = 12'h00a;
        tick(); tick(); tick();
        n_cmp++; if (err_any !== 1'b0) begin n_bad++; $display("FAIL drop_pre_err_any got %b want 0", err_any); end
        valid = '0;
        tick();
        n_cmp++; if (err_valid_drop !== 3'b001) begin n_bad++; $display("FAIL drop_bits got %b want 001", err_valid_drop); end
        n_cmp++; if (first_err_chan !== 2'd0 || first_err_code !== 2'd1) begin n_bad++;
            $display("FAIL drop_first got chan %0d code %0d want 0/1", first_err_chan, first_err_code); end
        n_cmp++; if (err_data_chg !== 3'b000) begin n_bad++; $display("FAIL drop_no_chg got %b want 000", err_data_chg); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        valid = 3'b110; ready = 3'b000; data = 12'h530;
        tick(); tick();
        valid = 3'b100; data = 12'h630;
        tick();
        n_cmp++; if (err_valid_drop !== 3'b010) begin n_bad++; $display("FAIL simul_drop got %b want 010", err_valid_drop); end
        n_cmp++; if (err_data_chg !== 3'b100) begin n_bad++; $display("FAIL simul_chg got %b want 100", err_data_chg); end
        n_cmp++; if (first_err_chan !== 2'd1 || first_err_code !== 2'd1) begin n_bad++;
            $display("FAIL simul_first got chan %0d code %0d want 1/1", first_err_chan, first_err_code); end
        valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        valid = 3'b001; ready = 3'b000; data = 12'h007;
        tick(); tick(); tick();
        n_cmp++; if (err_timeout !== 3'b000) begin n_bad++; $display("FAIL tmo_early got %b want 000", err_timeout); end
        tick();
        n_cmp++; if (err_timeout !== 3'b001) begin n_bad++; $display("FAIL tmo_4th got %b want 001", err_timeout); end
        n_cmp++; if (first_err_code !== 2'd3) begin n_bad++; $display("FAIL tmo_code got %0d want 3", first_err_code); end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (err_timeout !== 3'b000 || first_err_code !== 2'd0) begin n_bad++;
            $display("FAIL tmo_single got %b code %0d want 000/0", err_timeout, first_err_code); end
        ready = 3'b001;
        tick();
        valid = '0; ready = '0;
        tick();
        n_cmp++; if (xfer_cnt[0 +: 16] !== 16'd1) begin n_bad++; $display("FAIL tmo_xfer got %0d want 1", xfer_cnt[0 +: 16]); end
        n_cmp++; if (err_any !== 1'b0) begin n_bad++; $display("FAIL tmo_after_err_any got %b want 0", err_any); end
    endtask

    task automatic test_sat_clear();
        do_reset();
        valid = 3'b100; ready = 3'b100; data = 12'h100;
        for (int k = 0; k < 9; k++) tick();
        n_cmp++; if (s_xfer_cnt[6 +: 3] !== 3'd7) begin n_bad++; $display("FAIL sat_cnt got %0d want 7", s_xfer_cnt[6 +: 3]); end
        n_cmp++; if (xfer_cnt[32 +: 16] !== 16'd9) begin n_bad++; $display("FAIL wide_cnt got %0d want 9", xfer_cnt[32 +: 16]); end
        clr = 1'b1;
        tick();
        clr = 1'b0; valid = '0; ready = '0;
        n_cmp++; if (s_xfer_cnt[6 +: 3] !== 3'd1 || xfer_cnt[32 +: 16] !== 16'd1) begin n_bad++;
            $display("FAIL clr_xfer got %0d/%0d want 1/1", s_xfer_cnt[6 +: 3], xfer_cnt[32 +: 16]); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        valid = 3'b001; ready = 3'b000; data = 12'h003;
        tick(); tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1; valid = '0;
        tick(); tick();
        n_cmp++; if (err_any !== 1'b0 || {err_valid_drop, err_data_chg, err_timeout} !== '0) begin n_bad++;
            $display("FAIL rst_stall_err got any %b bits %b want 0", err_any, {err_valid_drop, err_data_chg, err_timeout}); end
        n_cmp++; if (xfer_cnt !== '0 || {first_err_chan, first_err_code} !== 4'h0) begin n_bad++;
            $display("FAIL rst_stall_outs got cnt %h first %h want 0", xfer_cnt, {first_err_chan, first_err_code}); end
    endtask

    task automatic test_random();
        logic [3:0] dh [NCH];
        logic [NCH*16-1:0] exp_w;
        logic [NCH*3-1:0]  exp_s;
        do_reset();
        for (int c = 0; c < NCH; c++) dh[c] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (run[c] > 0 && $urandom_range(9) != 0) begin
                    valid[c] = 1'b1;
                end else begin
                    valid[c] = ($urandom_range(3) != 0);
                    dh[c]    = 4'($urandom_range(15));
                end
                ready[c] = ($urandom_range(2) == 0);
                data[c*DW +: DW] = dh[c];
            end
            clr  = ($urandom_range(39) == 0);
            rstn = ($urandom_range(99) != 0);
            tick();
            for (int c = 0; c < NCH; c++) begin
                exp_w[c*16 +: 16] = 16'((cnt[c] > 65535) ? 65535 : cnt[c]);
                exp_s[c*3 +: 3]   = 3'((cnt[c] > 7) ? 7 : cnt[c]);
            end
            n_cmp++; if (xfer_cnt !== exp_w) begin n_bad++; $display("FAIL rnd_xfer cyc %0d got %h want %h", cyc, xfer_cnt, exp_w); end
            n_cmp++; if (s_xfer_cnt !== exp_s) begin n_bad++; $display("FAIL rnd_xfer_sat cyc %0d got %h want %h", cyc, s_xfer_cnt, exp_s); end
            n_cmp++; if (err_valid_drop !== m_drop) begin n_bad++; $display("FAIL rnd_drop cyc %0d got %b want %b", cyc, err_valid_drop, m_drop); end
            n_cmp++; if (err_data_chg !== m_chg) begin n_bad++; $display("FAIL rnd_chg cyc %0d got %b want %b", cyc, err_data_chg, m_chg); end
            n_cmp++; if (err_timeout !== m_tmo) begin n_bad++; $display("FAIL rnd_tmo cyc %0d got %b want %b", cyc, err_timeout, m_tmo); end
            n_cmp++; if (err_any !== |{m_drop, m_chg, m_tmo}) begin n_bad++; $display("FAIL rnd_any cyc %0d got %b", cyc, err_any); end
            n_cmp++; if (first_err_chan !== 2'(m_fchan) || first_err_code !== 2'(m_fcode)) begin n_bad++;
                $display("FAIL rnd_first cyc %0d got chan %0d code %0d want %0d/%0d", cyc, first_err_chan, first_err_code, m_fchan, m_fcode); end
        end
        clr = 1'b0; rstn = 1'b1; valid = '0; ready = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_drop();
        test_simultaneous();
        test_timeout();
        test_sat_clear();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
